// File: rtl/nn_layer_sequencer_pkg.sv
// Shared types and constants for the layer sequencer: state encoding and array geometry.
package nn_seq_pkg;

  localparam int unsigned ROWS       = 32;
  localparam int unsigned NUM_LAYERS = 4;
  localparam int unsigned DATA_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_WB      = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/nn_layer_sequencer.sv
// Sequences one inference: ifmap load, then per layer clear / 32 gated MAC rows / write-back.
module nn_layer_sequencer #(
  parameter int unsigned NUM_LAYERS = nn_seq_pkg::NUM_LAYERS,
  parameter int unsigned ROWS       = nn_seq_pkg::ROWS,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned LAYER_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LAYER_W:0]   cfg_num_layers,
  input  logic               weight_valid,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               ifmap_sel,
  output logic               mem_write_enable,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               acc_enable,
  output logic               acc_reset,
  output logic               weight_req,
  output logic [LAYER_W-1:0] layer_idx,
  output logic [ADDR_W-1:0]  row_idx
);

  import nn_seq_pkg::*;

  seq_state_t         r_state;
  seq_state_t         w_next_state;
  logic [LAYER_W:0]   r_num_layers;
  logic [LAYER_W-1:0] r_layer_idx;
  logic [ADDR_W-1:0]  r_row_idx;

  logic [LAYER_W:0]   w_num_clamped;
  logic               w_last_row;
  logic               w_last_layer;
  logic               w_accept_start;

  assign w_num_clamped  = (cfg_num_layers > (LAYER_W+1)'(NUM_LAYERS)) ?
                          (LAYER_W+1)'(NUM_LAYERS) : cfg_num_layers;
  assign w_last_row     = (r_row_idx == ADDR_W'(ROWS - 1));
  assign w_last_layer   = (((LAYER_W+1)'(r_layer_idx) + (LAYER_W+1)'(1)) == r_num_layers);
  assign w_accept_start = (r_state == ST_IDLE) && start && !abort;

  // State register and latched layer count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_num_layers <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept_start) r_num_layers <= w_num_clamped;
    end
  end

  // Row / layer counters; row wraps to 0 on the same edge that leaves COMPUTE
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      r_layer_idx <= '0;
      r_row_idx   <= '0;
    end else begin
      case (r_state)
        ST_CLEAR:   r_row_idx <= '0;
        ST_COMPUTE: if (weight_valid) r_row_idx <= w_last_row ? '0 : r_row_idx + ADDR_W'(1);
        ST_WB:      if (!w_last_layer) r_layer_idx <= r_layer_idx + LAYER_W'(1);
        ST_DONE: begin
          r_layer_idx <= '0;
          r_row_idx   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept_start) w_next_state = ST_LOAD;
      ST_LOAD:    w_next_state = (r_num_layers == '0) ? ST_DONE : ST_CLEAR;
      ST_CLEAR:   w_next_state = ST_COMPUTE;
      ST_COMPUTE: if (weight_valid && w_last_row) w_next_state = ST_WB;
      ST_WB:      w_next_state = w_last_layer ? ST_DONE : ST_CLEAR;
      ST_DONE:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
    if (abort && (r_state != ST_IDLE)) w_next_state = ST_IDLE;
  end

  // Output decode from registered state; acc_enable alone follows weight_valid
  always_comb begin
    busy             = (r_state != ST_IDLE);
    done             = 1'b0;
    ifmap_sel        = 1'b0;
    mem_write_enable = 1'b0;
    acc_enable       = 1'b0;
    acc_reset        = 1'b0;
    weight_req       = 1'b0;
    layer_idx        = r_layer_idx;
    row_idx          = r_row_idx;
    mem_addr         = r_row_idx;
    case (r_state)
      ST_IDLE:  acc_reset = 1'b1;
      ST_LOAD: begin
        ifmap_sel        = 1'b1;
        mem_write_enable = 1'b1;
      end
      ST_CLEAR: acc_reset = 1'b1;
      ST_COMPUTE: begin
        weight_req = 1'b1;
        acc_enable = weight_valid;
      end
      ST_WB:    mem_write_enable = 1'b1;
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: expected per-cycle outputs come from a schedule built from the layer/row rules.
module tb_nn_layer_sequencer;

  localparam int unsigned NL   = 4;
  localparam int unsigned NR   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned LW   = 2;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          ifmap_sel;
    logic          mem_we;
    logic          acc_reset;
    logic          weight_req;
    logic          acc_en;
    logic [LW-1:0] layer;
    logic [AW-1:0] row;
    logic [AW-1:0] addr;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset, start, weight_valid, abort;
  logic [LW:0]   cfg_num_layers;
  logic          busy, done, ifmap_sel, mem_write_enable, acc_enable, acc_reset, weight_req;
  logic [AW-1:0] mem_addr, row_idx;
  logic [LW-1:0] layer_idx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nn_layer_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .cfg_num_layers(cfg_num_layers),
    .weight_valid(weight_valid), .abort(abort), .busy(busy), .done(done),
    .ifmap_sel(ifmap_sel), .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
    .acc_enable(acc_enable), .acc_reset(acc_reset), .weight_req(weight_req),
    .layer_idx(layer_idx), .row_idx(row_idx)
  );

  function automatic obs_t mk(input bit b, input bit d, input bit i, input bit w, input bit a,
                              input bit r, input bit e, input int l, input int rw);
    obs_t o;
    o.busy = b; o.done = d; o.ifmap_sel = i; o.mem_we = w; o.acc_reset = a;
    o.weight_req = r; o.acc_en = e; o.layer = LW'(l); o.row = AW'(rw); o.addr = AW'(rw);
    return o;
  endfunction

  function automatic obs_t observe();
    return {busy, done, ifmap_sel, mem_write_enable, acc_reset, weight_req, acc_enable,
            layer_idx, row_idx, mem_addr};
  endfunction

  task automatic check_obs(input string tag, input int cyc, input obs_t got, input obs_t exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc %0d observed %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Weight availability: mode 0 always, mode 1 three-cycle gap at layer 1 row 10, mode 2 random
  function automatic bit pick_valid(input int mode, input int l, input int r, input int att);
    if (mode == 1) return !(l == 1 && r == 10 && att < 3);
    if (mode == 2) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  // Idle for one cycle with the given start/abort, expecting reset-state outputs
  task automatic idle_cycle(input string tag, input bit st, input bit ab);
    start = st; abort = ab; reset = 1'b0; weight_valid = 1'b0;
    @(negedge clk);
    check_obs(tag, 0, observe(), mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    @(posedge clk); #1;
  endtask

  task automatic run(input string tag, input int cfg, input int mode,
                     input int ab_l, input int ab_r, input bit use_reset);
    obs_t q[$];
    bit   vq[$];
    int   n, stalls, ai, done_off, writes;
    bit   v;
    n = (cfg > int'(NL)) ? int'(NL) : cfg;
    stalls = 0;
    q.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0)); vq.push_back(1'b0);
    for (int l = 0; l < n; l++) begin
      q.push_back(mk(1, 0, 0, 0, 1, 0, 0, l, 0)); vq.push_back(1'b0);
      for (int r = 0; r < int'(NR); r++) begin
        for (int att = 0; ; att++) begin
          v = pick_valid(mode, l, r, att);
          q.push_back(mk(1, 0, 0, 0, 0, 1, v, l, r)); vq.push_back(v);
          if (v) break;
          stalls++;
        end
      end
      q.push_back(mk(1, 0, 0, 1, 0, 0, 0, l, 0)); vq.push_back(1'b0);
    end
    q.push_back(mk(1, 1, 0, 0, 0, 0, 0, (n == 0) ? 0 : n - 1, 0)); vq.push_back(1'b0);

    ai = -1;
    if (ab_l >= 0)
      for (int i = 0; i < q.size(); i++)
        if (ai < 0 && q[i].weight_req && q[i].layer == LW'(ab_l) && q[i].row == AW'(ab_r)) ai = i;

    start = 1'b1; abort = 1'b0; reset = 1'b0; cfg_num_layers = (LW+1)'(cfg);
    weight_valid = 1'(($urandom_range(0, 1)));
    @(negedge clk);
    check_obs({tag, "_idle"}, 0, observe(), mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    @(posedge clk); #1;

    done_off = -1; writes = 0;
    for (int i = 0; i < q.size(); i++) begin
      weight_valid   = vq[i];
      start          = 1'(($urandom_range(0, 1)));
      cfg_num_layers = (LW+1)'($urandom_range(0, 7));
      abort          = (i == ai) && !use_reset;
      reset          = (i == ai) && use_reset;
      @(negedge clk);
      check_obs(tag, i + 1, observe(), q[i]);
      if (done === 1'b1 && done_off < 0) done_off = i + 1;
      if (mem_write_enable === 1'b1) writes++;
      @(posedge clk); #1;
      if (i == ai) break;
    end

    idle_cycle({tag, "_after"}, 1'b0, 1'b0);
    if (ai < 0) begin
      check_int({tag, "_done_cycle"}, done_off, 2 + 34 * n + stalls);
      check_int({tag, "_writes"}, writes, n + 1);
    end else begin
      check_int({tag, "_no_done"}, done_off, -1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; weight_valid = 1'b0; cfg_num_layers = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle_cycle("reset_state", 1'b0, 1'b0);

    run("four_layers", 4, 0, -1, 0, 1'b0);
    run("stall_l1_r10", 4, 1, -1, 0, 1'b0);
    run("zero_layers", 0, 0, -1, 0, 1'b0);
    run("clamp_seven", 7, 0, -1, 0, 1'b0);
    run("two_random", 2, 2, -1, 0, 1'b0);
    run("abort_l2_r5", 4, 2, 2, 5, 1'b0);
    run("after_abort", 3, 2, -1, 0, 1'b0);

    idle_cycle("abort_blocks_start", 1'b1, 1'b1);
    idle_cycle("still_idle", 1'b0, 1'b0);

    run("reset_compute", 4, 2, 1, 3, 1'b1);
    run("one_layer", 1, 2, -1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run always ends with a summary
  initial begin
    #200000;
    fails++;
    $display("FAIL timeout observed no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
